// File: rtl/countdown_timer_n.sv
// countdown_timer_n: N-digit, radix-R countdown timer.
// Digits are entered one at a time (start bumps the selected digit, mode
// moves to the next digit), then counted down to zero at one step every
// TICK_DIV clocks. Run can be paused/resumed with start and aborted with mode.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | digits held at zero, waiting for mode to begin entry
//   SET    | entering digit[sel]; start bumps it, mode advances sel
//   ARMED  | value entered; start runs it (or drops to IDLE if zero)
//   RUN    | prescaler counting, one borrow-chained decrement per tick
//   PAUSE  | digits and prescaler frozen until start (resume) or mode
//   DONE   | count reached zero, led1 lit until any button press
module countdown_timer_n #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int RADIX      = 10,
    parameter int TICK_DIV   = 50000000,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic [SEL_W-1:0]              sel,
    output logic [2:0]                    state,
    output logic                          running,
    output logic                          led1
);

    localparam int                 PRE_W     = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        ARMED = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                          state_r;
    logic [PRE_W-1:0]                prescale;
    logic                            start_q;
    logic                            mode_q;
    logic                            start_p;
    logic                            mode_p;
    logic [DIGIT_W-1:0]              cur_digit;
    logic [DIGIT_W-1:0]              inc_digit;
    logic [NUM_DIGITS*DIGIT_W-1:0]   dec_val;
    logic                            dec_zero;
    logic                            borrow;

    assign state = state_r;

    // mode wins when both buttons rise together, so start is masked by it
    assign mode_p  = mode & ~mode_q;
    assign start_p = start & ~start_q & ~mode_p;

    // Button history for rising-edge detection
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            start_q <= start;
            mode_q  <= mode;
        end
    end

    // Wrapping increment of the digit currently being set
    always_comb begin
        cur_digit = digits[int'(sel)*DIGIT_W +: DIGIT_W];
        inc_digit = (cur_digit == DIGIT_MAX) ? '0 : cur_digit + 1'b1;
    end

    // Borrow-chained decrement of the whole value, plus zero detect of the result
    always_comb begin
        dec_val = digits;
        borrow  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (borrow) begin
                if (digits[k*DIGIT_W +: DIGIT_W] == '0) begin
                    dec_val[k*DIGIT_W +: DIGIT_W] = DIGIT_MAX;
                end else begin
                    dec_val[k*DIGIT_W +: DIGIT_W] = digits[k*DIGIT_W +: DIGIT_W] - 1'b1;
                    borrow = 1'b0;
                end
            end
        end
        dec_zero = (dec_val == '0);
    end

    // Sequencing FSM with registered digits, select, prescaler and flags
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            digits   <= '0;
            sel      <= '0;
            prescale <= '0;
            running  <= 1'b0;
            led1     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    digits <= '0;
                    if (mode_p) begin
                        state_r <= SET;
                        sel     <= '0;
                    end
                end
                SET: begin
                    if (mode_p) begin
                        if (sel == SEL_LAST) begin
                            state_r <= ARMED;
                            sel     <= '0;
                        end else begin
                            sel <= sel + 1'b1;
                        end
                    end else if (start_p) begin
                        digits[int'(sel)*DIGIT_W +: DIGIT_W] <= inc_digit;
                    end
                end
                ARMED: begin
                    if (mode_p) begin
                        state_r <= IDLE;
                        digits  <= '0;
                    end else if (start_p) begin
                        if (|digits) begin
                            state_r  <= RUN;
                            running  <= 1'b1;
                            prescale <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (mode_p) begin
                        state_r  <= IDLE;
                        running  <= 1'b0;
                        digits   <= '0;
                        prescale <= '0;
                    end else if (prescale == PRE_LAST) begin
                        // a tick is never lost to a coincident pause request
                        prescale <= '0;
                        digits   <= dec_val;
                        if (dec_zero) begin
                            state_r <= DONE;
                            running <= 1'b0;
                            led1    <= 1'b1;
                        end else if (start_p) begin
                            state_r <= PAUSE;
                            running <= 1'b0;
                        end
                    end else if (start_p) begin
                        // prescaler held so resume finishes the interrupted step
                        state_r <= PAUSE;
                        running <= 1'b0;
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                PAUSE: begin
                    if (mode_p) begin
                        state_r  <= IDLE;
                        digits   <= '0;
                        prescale <= '0;
                    end else if (start_p) begin
                        state_r <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    digits <= '0;
                    if (start_p || mode_p) begin
                        state_r <= IDLE;
                        led1    <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    digits   <= '0;
                    sel      <= '0;
                    prescale <= '0;
                    running  <= 1'b0;
                    led1     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/countdown_timer_n.md
Name: countdown_timer_n

Overview:
- Parametrised successor to the fixed four-digit set/run timer.
- N digits of configurable radix are entered one at a time with the mode/start buttons, then counted down to zero at a prescaled tick rate.
- Adds pause/resume, abort, borrow-chained decrement and a done indicator.
- Sits between the button conditioning logic and the display digit driver.

Parameters:
- NUM_DIGITS, 4: number of digits. Digit 0 is least significant. Must be ≥ 2.
- DIGIT_W, 4: bits per digit.
- RADIX, 10: digit modulus. Must satisfy 2 ≤ RADIX ≤ 2^DIGIT_W.
- TICK_DIV, 50000000: clk_in cycles per countdown step. Must be ≥ 2.
- SEL_W, $clog2(NUM_DIGITS): width of the digit-select index. Derived; do not override.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level button: increment digit / arm / pause-resume / acknowledge.
- mode  input  1  level button: advance state / abort.
- digits  output  NUM_DIGITS*DIGIT_W  packed digit values; digit k occupies bits [k*DIGIT_W +: DIGIT_W].
- sel  output  SEL_W  index of the digit being set.
- state  output  3  current FSM state encoding.
- running  output  1  high while in RUN.
- led1  output  1  high while in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, digits=0, sel=0, prescaler=0, running=0, led1=0. Edge-detect history registers cleared to 0.
- Edge detect: start and mode are each registered once. Pulses are start_p = start & ~start_q and mode_p = mode & ~mode_q. A held button yields exactly one pulse.
- Priority: when start_p and mode_p occur in the same cycle, mode_p wins and start_p is ignored.
- All outputs are registered. A state change is visible one cycle after the pulse cycle.
- State encoding: IDLE=0, SET=1, ARMED=2, RUN=3, PAUSE=4, DONE=5. Unused codes go to IDLE.
- IDLE:
  - digits held at 0.
  - mode_p -> SET with sel=0.
- SET:
  - start_p: digit[sel] <= (digit[sel]==RADIX-1) ? 0 : digit[sel]+1.
  - mode_p with sel<NUM_DIGITS-1: sel+1, stay in SET.
  - mode_p with sel==NUM_DIGITS-1: -> ARMED, sel=0.
- ARMED:
  - start_p with any digit nonzero: -> RUN, prescaler=0.
  - start_p with all digits zero: -> IDLE. led1 stays 0.
  - mode_p: -> IDLE, digits cleared.
- RUN:
  - Prescaler increments every cycle. At TICK_DIV-1 it wraps to 0 and a tick occurs.
  - Tick decrements the multi-digit value: digit 0 decrements; a digit at 0 becomes RADIX-1 and borrows into the next digit.
  - If the post-decrement value is all zero -> DONE.
  - start_p: -> PAUSE, prescaler value held.
  - If a tick and start_p coincide, the decrement is applied. DONE takes priority over PAUSE.
  - mode_p: -> IDLE, digits and prescaler cleared, including on a tick cycle.
- PAUSE:
  - digits and prescaler frozen.
  - start_p: -> RUN, prescaler resumes from the held value.
  - mode_p: -> IDLE, cleared.
- DONE:
  - led1=1, digits all zero.
  - start_p or mode_p: -> IDLE, led1=0.
- running = (state==RUN); led1 = (state==DONE). Both are registered with state.
- Reset mid-operation: immediate async clear to reset values. The count is not retained.

Test Plan:
Bench parameters: NUM_DIGITS=4, RADIX=10, TICK_DIV=4. All button presses are held 3 cycles, with 3 released cycles between presses.
1. Basic countdown:
   - Stimulus: rst pulse; mode; start x2 (digit0=2); mode; start x1 (digit1=1); mode x3 -> ARMED; start.
   - Response: running=1 and digits=0012. After 4 cycles digits=0011. After 48 cycles from entering RUN, state=DONE, led1=1, digits=0000. Then start -> IDLE, led1=0.
2. Wrap in SET:
   - Stimulus: 10 start presses on digit0.
   - Response: digit0=0. An 11th press gives digit0=1. Other digits unchanged.
3. Borrow chain:
   - Stimulus: set value 0100; arm and run.
   - Response: first tick gives 0099. Value 1000 gives 0999.
4. Pause/resume:
   - Stimulus: start press mid-RUN (prescaler=2); hold PAUSE for 20 cycles; start press.
   - Response: digits unchanged through PAUSE. After resume, the next tick occurs 2 cycles after RUN re-entry.
5. Abort and priority:
   - Stimulus (a): mode press during RUN. Response: IDLE, digits=0000.
   - Stimulus (b): start and mode rising in the same cycle in PAUSE. Response: IDLE.
   - Stimulus (c): start in ARMED with value 0000. Response: IDLE, led1 never asserted.
6. Async reset mid-RUN:
   - Stimulus: rst asserted between clock edges with value 0573.
   - Response: digits=0, state=IDLE, running=0 before the next clk_in edge. Count resumes only after a full re-entry sequence.
